// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - radix-2 Booth sequencer driving an external registered add/sub stage
module booth_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     as_a,
    output logic [WIDTH-1:0]     as_b,
    output logic                 as_ctrl,
    input  logic [WIDTH-1:0]     as_o,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_CAPT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_q;
    logic [WIDTH-1:0]      r_m;
    logic                  r_qm1;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_product;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_sub;
    logic                  w_v;
    logic                  w_s;
    logic [WIDTH-1:0]      w_next_a;
    logic [WIDTH-1:0]      w_next_q;
    logic [CNT_W-1:0]      w_cnt_dec;

    assign w_sub     = r_q[0] & ~r_qm1;
    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // The adder wraps at WIDTH bits; v recovers the true sign of the WIDTH+1 bit sum.
    assign w_v = (w_sub ? (r_a[WIDTH-1] != r_m[WIDTH-1]) : (r_a[WIDTH-1] == r_m[WIDTH-1]))
               & (as_o[WIDTH-1] != r_a[WIDTH-1]);
    assign w_s = as_o[WIDTH-1] ^ w_v;

    always_comb begin
        w_next_a = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_next_q = {r_a[0], r_q[WIDTH-1:1]};
        if (r_state == S_CAPT) begin
            w_next_a = {w_s, as_o[WIDTH-1:1]};
            w_next_q = {as_o[0], r_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    r_state <= (r_q[0] ^ r_qm1) ? S_CAPT : S_SHIFT;
                end
                S_CAPT, S_SHIFT: begin
                    r_a   <= w_next_a;
                    r_q   <= w_next_q;
                    r_qm1 <= r_q[0];
                    r_cnt <= w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        r_product <= {w_next_a, w_next_q};
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_OP;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign as_a    = r_a;
    assign as_b    = r_m;
    assign as_ctrl = w_sub;
    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - scoreboard bench for booth_seq_ctrl with a registered add/sub model
module tb_booth_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic [3:0] as_a, as_b, as_o;
    logic       as_ctrl;
    logic [7:0] product;
    logic       busy, done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         sub_cycles = 0;
    logic [7:0] exp_q[$];
    bit         sweep_mode = 0;
    bit         have_prev = 0;
    int         prev_done_cyc = 0;

    booth_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .as_a         (as_a),
        .as_b         (as_b),
        .as_ctrl      (as_ctrl),
        .as_o         (as_o),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Registered 4-bit add/sub stage the sequencer drives.
    always @(posedge clk) begin
        as_o <= as_ctrl ? (as_a - as_b) : (as_a + as_b);
        cyc  <= cyc + 1;
    end

    always @(negedge clk) begin
        if (busy && as_ctrl) sub_cycles <= sub_cycles + 1;
    end

    // Monitor: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: done high at cycle %0d with no operation pending", cyc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    n_err++;
                    $display("FAIL product: got %h expected %h at cycle %0d", product, e, cyc);
                end
            end
            if (sweep_mode) begin
                if (have_prev) begin
                    n_cmp++;
                    if (cyc - prev_done_cyc != 10) begin
                        n_err++;
                        $display("FAIL done_spacing: got %0d cycles expected 10", cyc - prev_done_cyc);
                    end
                end
                have_prev = 1;
                prev_done_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] e, input int pulse_at);
        int lat;
        lat = 0;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(e);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == pulse_at) begin
                start        = 1'b1;
                multiplicand = 4'h1;
                multiplier   = 4'h1;
            end
            if (i == pulse_at + 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", 8'(lat), 8'd9);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no done within 30 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_product", product, 8'h00);
        check("rst_as_a", {4'd0, as_a}, 8'd0);
        check("rst_as_b", {4'd0, as_b}, 8'd0);
        check("rst_as_ctrl", {7'd0, as_ctrl}, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sub_cycles = 0;
        run_op(4'd3, 4'd2, 8'h06, 0);
        check("sub_cycles_3x2", 8'(sub_cycles), 8'd2);
        run_op(4'd3, 4'hC, 8'hF4, 0);
        run_op(4'hB, 4'd3, 8'hF1, 0);
        run_op(4'h8, 4'h8, 8'h40, 0);
        run_op(4'h8, 4'd7, 8'hC8, 0);
        run_op(4'd7, 4'd7, 8'h31, 3);
        repeat (15) @(negedge clk);
        check("idle_after_ignored_start", {7'd0, busy}, 8'd0);

        // Reset in cycle 5 of an operation.
        @(negedge clk);
        multiplicand = 4'd5;
        multiplier   = 4'd3;
        start        = 1'b1;
        exp_q.push_back(8'h0F);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("busy_before_reset", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_product", product, 8'h00);
        check("reset_done", {7'd0, done}, 8'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(4'd5, 4'd3, 8'h0F, 0);

        // Back-to-back sweep of all operand pairs with start held high.
        repeat (3) @(negedge clk);
        sweep_mode = 1;
        have_prev  = 0;
        for (int k = 0; k < 256; k++) begin
            logic [7:0]        kk;
            logic signed [7:0] em, eq, ep;
            kk = 8'(k);
            em = $signed(kk[7:4]);
            eq = $signed(kk[3:0]);
            ep = em * eq;
            if (k > 0) wait_done("sweep_done");
            else @(negedge clk);
            multiplicand = kk[7:4];
            multiplier   = kk[3:0];
            start        = 1'b1;
            exp_q.push_back(ep);
        end
        wait_done("sweep_last_done");
        start = 1'b0;
        repeat (15) @(negedge clk);
        sweep_mode = 0;
        check("queue_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
